filter_align_ctrl_5x5: RTL and testbench

Sequencer for the 5x5 line-buffer/window-align datapath. It tracks raster position for an incoming pixel stream (valid + start-of-frame marker) and generates that datapath's control fields:
- write enable
- line-memory select and rotation
- column-register select and rotation
- line/pixel addresses
It also flags when the 25-tap window is complete and reports the window's centre coordinate. It sits between the pixel source and the 5x5 align block, ahead of the filter MAC.

---
 rtl/filter_align_ctrl_5x5.sv | 131 +++++++++++++
 tb/tb_filter_align_ctrl_5x5.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/filter_align_ctrl_5x5.sv
// Raster-position sequencer for the 5x5 line-buffer / window-align datapath.
// Optional runtime geometry: define FILTER_ALIGN_CTRL_CFG_EN to add i_h_act/i_v_act.
module filter_align_ctrl_5x5 #(
  parameter int H_ACT = 1920,
  parameter int V_ACT = 1080,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  input  logic             i_sof,
`ifdef FILTER_ALIGN_CTRL_CFG_EN
  input  logic [CNT_W-1:0] i_h_act,
  input  logic [CNT_W-1:0] i_v_act,
`endif
  output logic             o_en,
  output logic [1:0]       o_sel_ln,
  output logic [2:0]       o_case_sel_ln,
  output logic [1:0]       o_sel_px,
  output logic [2:0]       o_case_sel_px,
  output logic [CNT_W-1:0] o_addr_ln,
  output logic [CNT_W-1:0] o_addr_px,
  output logic             o_win_valid,
  output logic [CNT_W-1:0] o_win_x,
  output logic [CNT_W-1:0] o_win_y,
  output logic             o_eof,
  output logic             o_sof_err,
  output logic             o_busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             sof_err_q, sof_err_d;
  logic [CNT_W-1:0] h_last, v_last;
  logic             acc;
  logic [CNT_W-1:0] cur_x, cur_y;
  logic             last_px;
  logic             win;

  // Gating with rstn keeps every output at 0 while reset is held.
  assign acc = rstn & i_valid & ((state_q == RUN) | i_sof);

`ifdef FILTER_ALIGN_CTRL_CFG_EN
  logic [CNT_W-1:0] h_last_q, v_last_q;

  // Stores (clamped size - 1) so the compare against x/y needs no extra logic.
  function automatic logic [CNT_W-1:0] clamp_last(input logic [CNT_W-1:0] sz);
    return (sz < CNT_W'(5)) ? CNT_W'(4) : sz - CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_last_q <= CNT_W'(H_ACT - 1);
      v_last_q <= CNT_W'(V_ACT - 1);
    end else if (acc && i_sof) begin
      h_last_q <= clamp_last(i_h_act);
      v_last_q <= clamp_last(i_v_act);
    end
  end

  assign h_last = h_last_q;
  assign v_last = v_last_q;
`else
  assign h_last = CNT_W'(H_ACT - 1);
  assign v_last = CNT_W'(V_ACT - 1);
`endif

  // An accepted SOF pixel is always (0,0), whatever the counters held.
  assign cur_x   = i_sof ? '0 : x_q;
  assign cur_y   = i_sof ? '0 : y_q;
  assign last_px = (x_q == h_last) && (y_q == v_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sof_err_q <= sof_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sof_err_d = 1'b0;
    if (acc) begin
      if (i_sof) begin
        state_d   = RUN;
        x_d       = CNT_W'(1);
        y_d       = '0;
        sof_err_d = (state_q == RUN) && ((x_q != '0) || (y_q != '0));
      end else if (x_q == h_last) begin
        x_d = '0;
        if (y_q == v_last) begin
          y_d     = '0;
          state_d = IDLE;
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  assign win = acc && (cur_x >= CNT_W'(4)) && (cur_y >= CNT_W'(4));

  assign o_en          = acc;
  assign o_sel_ln      = acc ? cur_y[1:0] : 2'b00;
  assign o_case_sel_ln = {1'b0, o_sel_ln};
  assign o_sel_px      = acc ? cur_x[1:0] : 2'b00;
  assign o_case_sel_px = {1'b0, o_sel_px};
  assign o_addr_ln     = acc ? cur_x : '0;
  assign o_addr_px     = acc ? cur_x : '0;
  assign o_win_valid   = win;
  assign o_win_x       = win ? cur_x - CNT_W'(2) : '0;
  assign o_win_y       = win ? cur_y - CNT_W'(2) : '0;
  assign o_eof         = acc && !i_sof && last_px;
  assign o_sof_err     = sof_err_q;
  assign o_busy        = (state_q == RUN);

endmodule

// File: tb/tb_filter_align_ctrl_5x5.sv
// Randomised self-checking bench for filter_align_ctrl_5x5 on an 8x6 frame,
// compared against a pixel-index model of the raster.
module tb_filter_align_ctrl_5x5;
  localparam int H = 8;
  localparam int V = 6;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_sof = 1'b0;
  logic         o_en, o_win_valid, o_eof, o_sof_err, o_busy;
  logic [1:0]   o_sel_ln, o_sel_px;
  logic [2:0]   o_case_sel_ln, o_case_sel_px;
  logic [W-1:0] o_addr_ln, o_addr_px, o_win_x, o_win_y;
`ifdef FILTER_ALIGN_CTRL_CFG_EN
  logic [W-1:0] i_h_act = W'(H);
  logic [W-1:0] i_v_act = W'(V);
`endif

  filter_align_ctrl_5x5 #(.H_ACT(H), .V_ACT(V), .CNT_W(W)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_sof(i_sof),
`ifdef FILTER_ALIGN_CTRL_CFG_EN
    .i_h_act(i_h_act), .i_v_act(i_v_act),
`endif
    .o_en(o_en), .o_sel_ln(o_sel_ln), .o_case_sel_ln(o_case_sel_ln),
    .o_sel_px(o_sel_px), .o_case_sel_px(o_case_sel_px),
    .o_addr_ln(o_addr_ln), .o_addr_px(o_addr_px),
    .o_win_valid(o_win_valid), .o_win_x(o_win_x), .o_win_y(o_win_y),
    .o_eof(o_eof), .o_sof_err(o_sof_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: frame active flag, linear pixel index within the frame, pending error pulse.
  bit m_busy = 0;
  int m_n = 0;
  bit m_err = 0;

  int en_cnt, win_cnt;
  int first_wx, first_wy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit v, input bit s);
    bit acc, win, eof;
    int pos, x, y;
    @(negedge clk);
    i_valid = v;
    i_sof   = s;
    #1;
    acc = v && (m_busy || s);
    pos = (acc && s) ? 0 : m_n;
    x   = pos % H;
    y   = pos / H;
    win = acc && x >= 4 && y >= 4;
    eof = acc && !s && pos == H * V - 1;
    check_eq("en",       32'(o_en),          32'(acc));
    check_eq("sel_ln",   32'(o_sel_ln),      acc ? 32'(y % 4) : 0);
    check_eq("case_ln",  32'(o_case_sel_ln), acc ? 32'(y % 4) : 0);
    check_eq("sel_px",   32'(o_sel_px),      acc ? 32'(x % 4) : 0);
    check_eq("case_px",  32'(o_case_sel_px), acc ? 32'(x % 4) : 0);
    check_eq("addr_ln",  32'(o_addr_ln),     acc ? 32'(x) : 0);
    check_eq("addr_px",  32'(o_addr_px),     acc ? 32'(x) : 0);
    check_eq("win",      32'(o_win_valid),   32'(win));
    check_eq("win_x",    32'(o_win_x),       win ? 32'(x - 2) : 0);
    check_eq("win_y",    32'(o_win_y),       win ? 32'(y - 2) : 0);
    check_eq("eof",      32'(o_eof),         32'(eof));
    check_eq("sof_err",  32'(o_sof_err),     32'(m_err));
    check_eq("busy",     32'(o_busy),        32'(m_busy));
    if (o_en) en_cnt++;
    if (o_win_valid) begin
      if (win_cnt == 0) begin
        first_wx = int'(o_win_x);
        first_wy = int'(o_win_y);
      end
      win_cnt++;
    end
    m_err = acc && s && m_busy && m_n != 0;
    if (acc) begin
      if (s) begin
        m_busy = 1;
        m_n    = 1;
      end else begin
        m_n++;
        if (m_n == H * V) begin
          m_n    = 0;
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn    = 1'b0;
    i_valid = 1'b1;
    i_sof   = 1'b0;
    #1;
    check_eq("rst_en",   32'(o_en),      0);
    check_eq("rst_busy", 32'(o_busy),    0);
    check_eq("rst_addr", 32'(o_addr_ln), 0);
    check_eq("rst_sel",  32'(o_sel_ln),  0);
    check_eq("rst_err",  32'(o_sof_err), 0);
    check_eq("rst_win",  32'(o_win_valid), 0);
    check_eq("rst_eof",  32'(o_eof),     0);
    m_busy = 0;
    m_n    = 0;
    m_err  = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("init_busy", 32'(o_busy), 0);
    check_eq("init_en",   32'(o_en),   0);
    check_eq("init_err",  32'(o_sof_err), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Continuous frame
    en_cnt = 0; win_cnt = 0;
    step(1, 1);
    for (int i = 1; i < H * V; i++) step(1, 0);
    step(0, 0);
    check_eq("f1_en_cnt",  32'(en_cnt), 48);
    check_eq("f1_win_cnt", 32'(win_cnt), 8);
    check_eq("f1_first_x", 32'(first_wx), 2);
    check_eq("f1_first_y", 32'(first_wy), 2);

    // Same frame with alternating gaps
    en_cnt = 0; win_cnt = 0;
    for (int i = 0; i < H * V; i++) begin
      step(1, i == 0);
      step(0, 0);
    end
    check_eq("f2_en_cnt",  32'(en_cnt), 48);
    check_eq("f2_win_cnt", 32'(win_cnt), 8);

    // Valid pixels while idle are dropped, then a SOF starts at x=0
    for (int i = 0; i < 5; i++) step(1, 0);
    step(1, 1);

    // Resync SOF at (3,2)
    for (int i = 1; i < 2 * H + 3; i++) step(1, 0);
    step(1, 1);
    step(1, 0);
    for (int i = 2; i < H * V; i++) step(1, 0);

    // Reset at (5,3), then non-SOF pixels are ignored
    step(1, 1);
    for (int i = 1; i < 3 * H + 5; i++) step(1, 0);
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1, 0);

    // Final pixel coinciding with SOF
    step(1, 1);
    for (int i = 1; i < H * V - 1; i++) step(1, 0);
    step(1, 1);
    step(1, 0);

    // Randomised traffic with occasional resyncs and gaps
    for (int i = 0; i < 1500; i++) begin
      bit v, s;
      v = ($urandom_range(0, 99) < 70);
      s = m_busy ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 9) == 0);
      step(v, s);
    end
    pulse_reset();
    step(1, 1);
    step(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
